// File: rtl/z16_decode_stage.sv
// Z16 decode stage: one-entry holding register with a register-busy scoreboard.
// Issues decoded instructions to execute; stalls on read/write hazards until writeback.
module z16_decode_stage #(
  parameter int XLEN  = 16,
  parameter int CNT_W = 16,
  parameter int SB_EN = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [15:0]      i_instr,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [3:0]       o_opcode,
  output logic [3:0]       o_rd_addr,
  output logic [3:0]       o_rs1_addr,
  output logic [3:0]       o_rs2_addr,
  output logic [XLEN-1:0]  o_imm,
  output logic             o_rd_we,
  output logic             o_mem_we,
  output logic [3:0]       o_alu_ctrl,
  input  logic             i_wb_valid,
  input  logic [3:0]       i_wb_addr,
  input  logic             i_flush,
  output logic [15:0]      o_busy,
  output logic [CNT_W-1:0] o_stall_cnt
);

  logic [3:0]       d_opcode;
  logic [3:0]       d_rs1;
  logic [XLEN-1:0]  d_imm;
  logic             d_rd_we;
  logic             d_mem_we;
  logic [3:0]       d_alu;
  logic             d_use1;
  logic             d_use2;

  logic             hold_valid;
  logic [3:0]       h_opcode;
  logic [3:0]       h_rd;
  logic [3:0]       h_rs1;
  logic [3:0]       h_rs2;
  logic [XLEN-1:0]  h_imm;
  logic             h_rd_we;
  logic             h_mem_we;
  logic [3:0]       h_alu;
  logic             h_use1;
  logic             h_use2;

  logic [15:0]      busy;
  logic [15:0]      busy_d;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_d;
  logic             hazard;
  logic             issue;
  logic             accept;

  always_comb begin
    d_opcode = i_instr[3:0];
    d_rs1    = (d_opcode == 4'h9) ? i_instr[7:4] : i_instr[11:8];
    d_imm    = '0;
    case (d_opcode)
      4'h9:             d_imm = {{(XLEN-8){i_instr[15]}}, i_instr[15:8]};
      4'hA, 4'hC, 4'hD: d_imm = {{(XLEN-4){i_instr[15]}}, i_instr[15:12]};
      4'hB:             d_imm = {{(XLEN-4){i_instr[7]}}, i_instr[7:4]};
      default:          d_imm = '0;
    endcase
    d_rd_we  = (d_opcode <= 4'hA) || (d_opcode == 4'hC) || (d_opcode == 4'hD);
    d_mem_we = (d_opcode == 4'hB);
    d_alu    = (d_opcode <= 4'h8) ? d_opcode : 4'h0;
    d_use1   = (d_opcode <= 4'hD);
    d_use2   = (d_opcode <= 4'h8) || ((d_opcode >= 4'hB) && (d_opcode <= 4'hD));
  end

  // Hazard looks only at registered busy bits; a same-cycle writeback does not bypass.
  always_comb begin
    hazard = 1'b0;
    if (SB_EN != 0) begin
      hazard = hold_valid && ((h_use1 && busy[h_rs1]) || (h_use2 && busy[h_rs2]) ||
                              (h_rd_we && busy[h_rd]));
    end
  end

  assign o_valid = hold_valid && !hazard && !i_flush;
  assign issue   = o_valid && i_ready;
  assign o_ready = (!hold_valid || issue) && !i_flush;
  assign accept  = i_valid && o_ready;

  // Set after clear so an issue to the same register wins over its writeback.
  always_comb begin
    busy_d = busy;
    if (i_wb_valid) busy_d[i_wb_addr] = 1'b0;
    if (issue && h_rd_we) busy_d[h_rd] = 1'b1;
    if (SB_EN == 0) busy_d = '0;
  end

  always_comb begin
    stall_d = stall_cnt;
    if (hazard && !i_flush && !(&stall_cnt)) stall_d = stall_cnt + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_valid <= 1'b0;
      h_opcode   <= '0;
      h_rd       <= '0;
      h_rs1      <= '0;
      h_rs2      <= '0;
      h_imm      <= '0;
      h_rd_we    <= 1'b0;
      h_mem_we   <= 1'b0;
      h_alu      <= '0;
      h_use1     <= 1'b0;
      h_use2     <= 1'b0;
      busy       <= '0;
      stall_cnt  <= '0;
    end else begin
      if (i_flush) begin
        hold_valid <= 1'b0;
      end else if (accept) begin
        hold_valid <= 1'b1;
        h_opcode   <= d_opcode;
        h_rd       <= i_instr[7:4];
        h_rs1      <= d_rs1;
        h_rs2      <= i_instr[15:12];
        h_imm      <= d_imm;
        h_rd_we    <= d_rd_we;
        h_mem_we   <= d_mem_we;
        h_alu      <= d_alu;
        h_use1     <= d_use1;
        h_use2     <= d_use2;
      end else if (issue) begin
        hold_valid <= 1'b0;
      end
      busy      <= busy_d;
      stall_cnt <= stall_d;
    end
  end

  assign o_opcode    = h_opcode;
  assign o_rd_addr   = h_rd;
  assign o_rs1_addr  = h_rs1;
  assign o_rs2_addr  = h_rs2;
  assign o_imm       = h_imm;
  assign o_rd_we     = h_rd_we;
  assign o_mem_we    = h_mem_we;
  assign o_alu_ctrl  = h_alu;
  assign o_busy      = busy;
  assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_z16_decode_stage.sv
// Bench for z16_decode_stage: directed scenarios plus random traffic against a
// transaction-level model; issued instructions are scoreboarded by a monitor.
module tb_z16_decode_stage;

  logic        i_clk, i_rst;
  logic        i_valid, i_ready, i_wb_valid, i_flush;
  logic [15:0] i_instr;
  logic [3:0]  i_wb_addr;
  logic        o_ready, o_valid, o_rd_we, o_mem_we;
  logic [3:0]  o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_alu_ctrl;
  logic [15:0] o_imm, o_busy, o_stall_cnt;

  z16_decode_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr),
    .o_valid(o_valid), .i_ready(i_ready), .o_opcode(o_opcode), .o_rd_addr(o_rd_addr),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_imm(o_imm), .o_rd_we(o_rd_we),
    .o_mem_we(o_mem_we), .o_alu_ctrl(o_alu_ctrl), .i_wb_valid(i_wb_valid),
    .i_wb_addr(i_wb_addr), .i_flush(i_flush), .o_busy(o_busy), .o_stall_cnt(o_stall_cnt)
  );

  // Secondary instances: 2-bit stall counter, and scoreboard disabled.
  logic        s_valid, s_ready;
  logic [15:0] s_instr;
  logic        a_ready, a_valid, a_rd_we, a_mem_we, n_ready, n_valid, n_rd_we, n_mem_we;
  logic [3:0]  a_op, a_rd, a_rs1, a_rs2, a_alu, n_op, n_rd, n_rs1, n_rs2, n_alu;
  logic [15:0] a_imm, a_busy, n_imm, n_busy, n_cnt;
  logic [1:0]  a_cnt;

  z16_decode_stage #(.CNT_W(2)) dut_sat (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(s_valid), .o_ready(a_ready), .i_instr(s_instr),
    .o_valid(a_valid), .i_ready(s_ready), .o_opcode(a_op), .o_rd_addr(a_rd),
    .o_rs1_addr(a_rs1), .o_rs2_addr(a_rs2), .o_imm(a_imm), .o_rd_we(a_rd_we),
    .o_mem_we(a_mem_we), .o_alu_ctrl(a_alu), .i_wb_valid(1'b0), .i_wb_addr(4'h0),
    .i_flush(1'b0), .o_busy(a_busy), .o_stall_cnt(a_cnt)
  );

  z16_decode_stage #(.SB_EN(0)) dut_nosb (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(s_valid), .o_ready(n_ready), .i_instr(s_instr),
    .o_valid(n_valid), .i_ready(s_ready), .o_opcode(n_op), .o_rd_addr(n_rd),
    .o_rs1_addr(n_rs1), .o_rs2_addr(n_rs2), .o_imm(n_imm), .o_rd_we(n_rd_we),
    .o_mem_we(n_mem_we), .o_alu_ctrl(n_alu), .i_wb_valid(1'b0), .i_wb_addr(4'h0),
    .i_flush(1'b0), .o_busy(n_busy), .o_stall_cnt(n_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  op, rd, rs1, rs2, alu;
    logic [15:0] imm;
    logic        rd_we, mem_we, u1, u2;
  } dec_t;

  int total = 0;
  int bad   = 0;
  dec_t exp_q[$];

  // Model state: what the stage should be holding and which registers are pending.
  logic        m_hold;
  logic [15:0] m_instr;
  logic [15:0] m_busy;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic dec_t ref_dec(input logic [15:0] x);
    dec_t d;
    int   op;
    int   imm;
    op       = int'(x[3:0]);
    d.op     = x[3:0];
    d.rd     = x[7:4];
    d.rs2    = x[15:12];
    d.rs1    = (op == 9) ? x[7:4] : x[11:8];
    if (op == 9) imm = sext(int'(x[15:8]), 8);
    else if (op == 10 || op == 12 || op == 13) imm = sext(int'(x[15:12]), 4);
    else if (op == 11) imm = sext(int'(x[7:4]), 4);
    else imm = 0;
    d.imm    = imm[15:0];
    d.rd_we  = (op <= 10) || (op == 12) || (op == 13);
    d.mem_we = (op == 11);
    d.alu    = (op <= 8) ? x[3:0] : 4'h0;
    d.u1     = (op <= 13);
    d.u2     = (op <= 8) || (op >= 11 && op <= 13);
    return d;
  endfunction

  // One clock cycle: drive inputs at posedge+1, predict handshake, advance model at the edge.
  task automatic step(input logic v, input logic [15:0] ins, input logic rdy,
                      input logic wbv, input logic [3:0] wba, input logic fl);
    dec_t h;
    logic haz, e_valid, e_issue, e_ready, e_acc;
    i_valid = v; i_instr = ins; i_ready = rdy; i_wb_valid = wbv; i_wb_addr = wba; i_flush = fl;
    #1;
    h       = ref_dec(m_instr);
    haz     = m_hold && ((h.u1 && m_busy[h.rs1]) || (h.u2 && m_busy[h.rs2]) ||
                         (h.rd_we && m_busy[h.rd]));
    e_valid = m_hold && !haz && !fl;
    e_issue = e_valid && rdy;
    e_ready = (!m_hold || e_issue) && !fl;
    e_acc   = v && e_ready;
    check("o_valid", {31'd0, o_valid}, {31'd0, e_valid});
    check("o_ready", {31'd0, o_ready}, {31'd0, e_ready});
    check("o_busy", {16'd0, o_busy}, {16'd0, m_busy});
    check("o_stall_cnt", {16'd0, o_stall_cnt}, m_cnt);
    if (fl && m_hold && exp_q.size() > 0) void'(exp_q.pop_front());
    if (e_acc) exp_q.push_back(ref_dec(ins));
    @(posedge i_clk);
    if (wbv) m_busy[wba] = 1'b0;
    if (e_issue && h.rd_we) m_busy[h.rd] = 1'b1;
    if (haz && !fl && m_cnt < 65535) m_cnt++;
    if (fl) m_hold = 1'b0;
    else if (e_acc) begin m_hold = 1'b1; m_instr = ins; end
    else if (e_issue) m_hold = 1'b0;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    check({tag, "_busy"}, {16'd0, o_busy}, 32'd0);
    check({tag, "_cnt"}, {16'd0, o_stall_cnt}, 32'd0);
    check({tag, "_fields"}, {o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_alu_ctrl, 12'd0},
          32'd0);
    check({tag, "_imm_we"}, {14'd0, o_imm, o_rd_we, o_mem_we}, 32'd0);
  endtask

  // Asynchronous reset pulse between edges, starting from posedge+1.
  task automatic do_reset(input string tag);
    i_valid = 1'b0; i_flush = 1'b0; i_wb_valid = 1'b0;
    #2 i_rst = 1'b1;
    #1 check_reset_outputs(tag);
    #8 i_rst = 1'b0;
    #1;
    check({tag, "_ready_after"}, {31'd0, o_ready}, 32'd1);
    check({tag, "_valid_after"}, {31'd0, o_valid}, 32'd0);
    m_hold = 1'b0; m_busy = '0; m_cnt = 0; m_instr = '0;
    exp_q.delete();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: every issue is compared against the oldest outstanding accepted instruction.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: issue of opcode %0h with no expected entry", o_opcode);
      end else begin
        dec_t e;
        e = exp_q.pop_front();
        check("sb_opcode", {28'd0, o_opcode}, {28'd0, e.op});
        check("sb_rd", {28'd0, o_rd_addr}, {28'd0, e.rd});
        check("sb_rs1", {28'd0, o_rs1_addr}, {28'd0, e.rs1});
        check("sb_rs2", {28'd0, o_rs2_addr}, {28'd0, e.rs2});
        check("sb_imm", {16'd0, o_imm}, {16'd0, e.imm});
        check("sb_rd_we", {31'd0, o_rd_we}, {31'd0, e.rd_we});
        check("sb_mem_we", {31'd0, o_mem_we}, {31'd0, e.mem_we});
        check("sb_alu", {28'd0, o_alu_ctrl}, {28'd0, e.alu});
      end
    end
  end

  initial begin
    logic [15:0] saved_busy;
    i_rst = 1'b0; i_valid = 1'b0; i_instr = '0; i_ready = 1'b0; i_wb_valid = 1'b0;
    i_wb_addr = '0; i_flush = 1'b0; s_valid = 1'b0; s_instr = '0; s_ready = 1'b0;
    m_hold = 1'b0; m_busy = '0; m_cnt = 0; m_instr = '0;
    #1 i_rst = 1'b1;
    #2 check_reset_outputs("rst0");
    #9 i_rst = 1'b0;
    #1 check("rst0_ready", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk);
    #1;

    // Decode of an opcode-9 instruction.
    step(1'b1, 16'hF859, 1'b1, 1'b0, 4'h0, 1'b0);
    check("dec_valid", {31'd0, o_valid}, 32'd1);
    check("dec_fields", {16'd0, o_opcode, o_rd_addr, o_rs1_addr, o_alu_ctrl}, 32'h0000_9550);
    check("dec_imm", {15'd0, o_imm, o_rd_we}, {15'd0, 16'hFFF8, 1'b1});
    // Issue sets busy[5] while a writeback to 5 clears it: set wins.
    step(1'b0, 16'h0, 1'b1, 1'b1, 4'h5, 1'b0);
    check("set_wins", {16'd0, o_busy}, 32'h0020);
    step(1'b0, 16'h0, 1'b1, 1'b1, 4'h5, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b1, 4'h9, 1'b0);
    check("wb_clear_idle", {16'd0, o_busy}, 32'h0000);

    // RAW stall on r3.
    step(1'b1, 16'h1230, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 16'h0331, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 1'b0);
    check("raw_stall_cnt", {16'd0, o_stall_cnt}, 32'd3);
    check("raw_blocked", {31'd0, o_valid}, 32'd0);
    step(1'b0, 16'h0, 1'b1, 1'b1, 4'h3, 1'b0);
    check("raw_release", {31'd0, o_valid}, 32'd1);
    step(1'b0, 16'h0, 1'b1, 1'b1, 4'h3, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b1, 4'h3, 1'b0);

    // Back-pressure: X held for 5 cycles, then X issues as Y is accepted.
    step(1'b1, 16'h2102, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 16'h5463, 1'b0, 1'b0, 4'h0, 1'b0);
      check("bp_stable", {24'd0, o_opcode, o_rd_addr}, 32'h20);
    end
    step(1'b1, 16'h5463, 1'b1, 1'b0, 4'h0, 1'b0);
    check("bp_no_bubble", {27'd0, o_valid, o_opcode}, {27'd0, 1'b1, 4'h3});
    step(1'b0, 16'h0, 1'b1, 1'b1, 4'h0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b1, 4'h6, 1'b0);

    // Flush of a hazard-free held instruction.
    step(1'b1, 16'h0042, 1'b1, 1'b0, 4'h0, 1'b0);
    saved_busy = o_busy;
    step(1'b1, 16'h0012, 1'b1, 1'b0, 4'h0, 1'b1);
    i_flush = 1'b0;
    #1;
    check("flush_busy", {16'd0, o_busy}, {16'd0, saved_busy});
    check("flush_cleared", {30'd0, o_valid, o_ready}, 32'd1);

    // Saturating 2-bit counter and scoreboard-off instance.
    for (int k = 0; k < 6; k++) begin
      s_valid = (k < 2);
      s_instr = (k == 0) ? 16'h1230 : 16'h0331;
      s_ready = 1'b1;
      step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 1'b0);
      if (k == 1) begin
        check("nosb_no_stall", {31'd0, n_valid}, 32'd1);
        check("sat_hazard", {31'd0, a_valid}, 32'd0);
      end
      if (k == 4) check("sat_reach3", {30'd0, a_cnt}, 32'd3);
    end
    check("sat_hold3", {30'd0, a_cnt}, 32'd3);
    check("sat_busy", {16'd0, a_busy}, 32'h0008);
    check("nosb_busy", {16'd0, n_busy}, 32'd0);
    check("nosb_cnt", {16'd0, n_cnt}, 32'd0);
    s_valid = 1'b0;

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 3) != 0), 16'($urandom()), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
    end

    do_reset("rst_mid");
    step(1'b1, 16'h1230, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 16'h0331, 1'b1, 1'b0, 4'h0, 1'b0);
    check("pre_rst_busy", {16'd0, o_busy}, 32'h0008);
    do_reset("rst_async");
    for (int n = 0; n < 40; n++) begin
      step(($urandom_range(0, 1) == 1), 16'($urandom()), 1'b1, 1'b1,
           4'($urandom_range(0, 15)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
